// File: rtl/blink_pkg.sv
// Shared definitions for the blink monitor and the blink generator.
package blink_pkg;

  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF = 1000;

  // Monitor FSM state
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2,
    S_STUCK = 2'd3
  } mon_state_e;

  // Blink generator output phase
  typedef enum logic {
    G_LOW  = 1'b0,
    G_HIGH = 1'b1
  } gen_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  // Metastability filter: d -> s1 -> s2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/blink_monitor.sv
// Measures period and high time of an asynchronous blink line and flags a
// line that has stopped toggling.
module blink_monitor
  import blink_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             led_in,
  output logic             period_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ToLim  = CNT_W'(TIMEOUT);

  logic s2, s3;
  logic rise, fall;

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;      // cycles since last rise
  logic [CNT_W-1:0] hcap_q, hcap_d;    // count captured at the fall
  logic [CNT_W-1:0] tcnt_q, tcnt_d;    // cycles since any edge
  logic             ref_q, ref_d;      // previous rise usable as reference
  logic             pv_q, pv_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic             stuck_q, stuck_d;
  logic             lvl_q, lvl_d;

  logic [CNT_W-1:0] cnt_inc, tcnt_inc;
  logic             timeout_hit;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (led_in),
    .q     (s2)
  );

  // Delayed copy of the synchronized line for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s3 <= 1'b0;
    else        s3 <= s2;
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
  assign tcnt_inc = (tcnt_q == CntMax) ? tcnt_q : tcnt_q + CNT_W'(1);
  // An edge on the expiry cycle wins over the timeout
  assign timeout_hit = !(rise || fall) && (tcnt_inc >= ToLim);

  // Next-state, measurement and alarm logic
  always_comb begin
    state_d = state_q;
    hcap_d  = hcap_q;
    ref_d   = ref_q;
    pv_d    = 1'b0;
    per_d   = per_q;
    hi_d    = hi_q;
    stuck_d = stuck_q;
    lvl_d   = lvl_q;
    // Count is 1 on the cycle after a rise
    cnt_d   = rise ? CNT_W'(1) : cnt_inc;
    tcnt_d  = (rise || fall) ? '0 : tcnt_inc;

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_HIGH;
          hcap_d  = '0;
          ref_d   = 1'b1;
        end
      end
      S_HIGH: begin
        if (fall) begin
          state_d = S_LOW;
          hcap_d  = cnt_q;
        end
      end
      S_LOW: begin
        if (rise) begin
          state_d = S_HIGH;
          ref_d   = 1'b1;
          if (ref_q) begin
            pv_d  = 1'b1;
            per_d = cnt_q;
            hi_d  = hcap_q;
          end
        end
      end
      S_STUCK: begin
        if (rise) begin
          state_d = S_HIGH;
          stuck_d = 1'b0;
          ref_d   = 1'b1;
        end else if (fall) begin
          // No rise has been seen yet, so the next rise cannot close a period
          state_d = S_LOW;
          stuck_d = 1'b0;
          ref_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_STUCK) && timeout_hit) begin
      state_d = S_STUCK;
      stuck_d = 1'b1;
      lvl_d   = s2;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hcap_q  <= '0;
      tcnt_q  <= '0;
      ref_q   <= 1'b0;
      pv_q    <= 1'b0;
      per_q   <= '0;
      hi_q    <= '0;
      stuck_q <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcap_q  <= hcap_d;
      tcnt_q  <= tcnt_d;
      ref_q   <= ref_d;
      pv_q    <= pv_d;
      per_q   <= per_d;
      hi_q    <= hi_d;
      stuck_q <= stuck_d;
      lvl_q   <= lvl_d;
    end
  end

  assign period_valid = pv_q;
  assign period       = per_q;
  assign high_time    = hi_q;
  assign stuck        = stuck_q;
  assign stuck_level  = lvl_q;

endmodule

// File: tb/tb_blink_monitor.sv
// Directed bench for blink_monitor: default instance (16 bit, timeout 1000)
// and a narrow instance (4 bit, timeout 15) for saturation.
module tb_blink_monitor;

  logic clk;
  logic rst_n;
  logic led_a, led_b;

  logic        pv_a, stuck_a, lvl_a;
  logic [15:0] per_a, hi_a;
  logic        pv_b, stuck_b, lvl_b;
  logic [3:0]  per_b, hi_b;

  int n_vec;
  int n_err;
  int cyc;
  int npulse_a, npulse_b;
  int last_per_a, last_hi_a, last_per_b, last_hi_b;
  int first_cyc_a, last_cyc_a;
  int p;

  blink_monitor u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .led_in       (led_a),
    .period_valid (pv_a),
    .period       (per_a),
    .high_time    (hi_a),
    .stuck        (stuck_a),
    .stuck_level  (lvl_a)
  );

  blink_monitor #(
    .CNT_W   (4),
    .TIMEOUT (15)
  ) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .led_in       (led_b),
    .period_valid (pv_b),
    .period       (per_b),
    .high_time    (hi_b),
    .stuck        (stuck_b),
    .stuck_level  (lvl_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (pv_a) begin
      if (npulse_a == 0) first_cyc_a = cyc;
      npulse_a   = npulse_a + 1;
      last_per_a = int'(per_a);
      last_hi_a  = int'(hi_a);
      last_cyc_a = cyc;
    end
    if (pv_b) begin
      npulse_b   = npulse_b + 1;
      last_per_b = int'(per_b);
      last_hi_b  = int'(hi_b);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hold a level for n rising edges, ending 1 time unit after the last edge
  task automatic drive_a(input logic v, input int n);
    led_a = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic v, input int n);
    led_b = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    npulse_a = 0; npulse_b = 0;
    last_per_a = 0; last_hi_a = 0; last_per_b = 0; last_hi_b = 0;
    first_cyc_a = 0; last_cyc_a = 0; p = 0;
    rst_n = 1'b0; led_a = 1'b0; led_b = 1'b0;
    #12;
    check_eq("rst_pv",     32'(pv_a),    0);
    check_eq("rst_period", 32'(per_a),   0);
    check_eq("rst_high",   32'(hi_a),    0);
    check_eq("rst_stuck",  32'(stuck_a), 0);
    check_eq("rst_level",  32'(lvl_a),   0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Narrow instance: idle timeout with line low, then saturated period
    drive_b(1'b0, 20);
    check_eq("b_idle_stuck", 32'(stuck_b), 1);
    check_eq("b_idle_level", 32'(lvl_b),   0);
    npulse_b = 0;
    for (int i = 0; i < 3; i++) begin
      drive_b(1'b1, 10);
      drive_b(1'b0, 10);
    end
    check_eq("b_sat_pulses", 32'(npulse_b),   2);
    check_eq("b_sat_period", 32'(last_per_b), 15);
    check_eq("b_sat_high",   32'(last_hi_b),  10);
    check_eq("b_sat_stuck",  32'(stuck_b),    0);

    // Toggle every clock: 20 rises, first one gives no pulse
    npulse_a = 0;
    for (int i = 0; i < 20; i++) begin
      drive_a(1'b1, 1);
      drive_a(1'b0, 1);
    end
    drive_a(1'b0, 4);
    check_eq("tog_pulses",  32'(npulse_a),   19);
    check_eq("tog_period",  32'(last_per_a), 2);
    check_eq("tog_high",    32'(last_hi_a),  1);
    check_eq("tog_spacing", 32'(last_cyc_a - first_cyc_a), 36);
    check_eq("tog_stuck",   32'(stuck_a),    0);

    // Asynchronous reset in the middle of a high phase
    drive_a(1'b1, 5);
    rst_n = 1'b0;
    #2;
    check_eq("mid_rst_pv",     32'(pv_a),    0);
    check_eq("mid_rst_period", 32'(per_a),   0);
    check_eq("mid_rst_high",   32'(hi_a),    0);
    check_eq("mid_rst_stuck",  32'(stuck_a), 0);
    check_eq("mid_rst_level",  32'(lvl_a),   0);
    led_a = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_a(1'b0, 3);

    // 3 high / 5 low: 5 rises, 4 pulses; latency on the last one
    npulse_a = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) p = cyc;
      drive_a(1'b1, 3);
      drive_a(1'b0, 5);
    end
    check_eq("p35_pulses",  32'(npulse_a),   4);
    check_eq("p35_period",  32'(last_per_a), 8);
    check_eq("p35_high",    32'(last_hi_a),  3);
    check_eq("p35_latency", 32'(last_cyc_a), 32'(p + 3));

    // Held high: rise registered 3 edges after the input change
    drive_a(1'b1, 1002);
    check_eq("hold_not_yet", 32'(stuck_a), 0);
    drive_a(1'b1, 1);
    check_eq("hold_stuck", 32'(stuck_a), 1);
    check_eq("hold_level", 32'(lvl_a),   1);
    drive_a(1'b0, 2);
    check_eq("fall_still_stuck", 32'(stuck_a), 1);
    drive_a(1'b0, 1);
    check_eq("fall_clears", 32'(stuck_a), 0);
    npulse_a = 0;
    drive_a(1'b0, 2);
    drive_a(1'b1, 4);
    drive_a(1'b0, 6);
    drive_a(1'b1, 4);
    drive_a(1'b0, 6);
    check_eq("post_pulses",     32'(npulse_a),   1);
    check_eq("post_period",     32'(last_per_a), 10);
    check_eq("post_high",       32'(last_hi_a),  4);
    check_eq("post_level_held", 32'(lvl_a),      1);

    // Rise lands exactly on the expiry edge (1000 cycles after the last fall)
    drive_a(1'b0, 994);
    npulse_a = 0;
    drive_a(1'b1, 3);
    check_eq("coinc_stuck", 32'(stuck_a), 0);
    drive_a(1'b1, 2);
    drive_a(1'b0, 5);
    drive_a(1'b1, 1);
    drive_a(1'b0, 5);
    check_eq("coinc_pulses", 32'(npulse_a),   2);
    check_eq("coinc_period", 32'(last_per_a), 10);
    check_eq("coinc_high",   32'(last_hi_a),  5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/blink_monitor.md
BLINK_MONITOR -- requirements
Module: blink_monitor

Interface
REQ-001 Parameter CNT_W, default 16: width of period and high-time counters and outputs.
REQ-002 Parameter TIMEOUT, default 1000: cycles without any input edge before the stuck alarm is raised; legal range 2 to 2^CNT_W-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 led_in  input  1  monitored blink line, asynchronous to clk.
REQ-006 period_valid  output  1  one-cycle pulse; period and high_time are valid.
REQ-007 period  output  CNT_W  cycles between the last two rising edges of led_in.
REQ-008 high_time  output  CNT_W  cycles led_in was high within the reported period.
REQ-009 stuck  output  1  level; no edge seen for TIMEOUT cycles.
REQ-010 stuck_level  output  1  synchronized led_in value when stuck was raised.

Function
REQ-011 led_in SHALL pass through a 2-flop synchronizer (s1, s2), with a third flop s3 for edge detection: rise = s2 & ~s3, fall = ~s2 & s3.
REQ-012 FSM states SHALL be S_IDLE, S_HIGH, S_LOW, S_STUCK.
REQ-013 S_IDLE: rise -> S_HIGH, counters cleared, no period_valid; fall ignored but restarts timeout.
REQ-014 S_HIGH: fall -> S_LOW, high-time capture register loaded with the current period count.
REQ-015 S_LOW: rise -> S_HIGH, period_valid pulsed, period = cycles since previous rise, high_time = captured value, period counter restarted.
REQ-016 Period counting: on a rise, the count SHALL be 1 on the cycle after the rise; a led_in toggling every clock therefore yields period = 2, high_time = 1.
REQ-017 Period and high-time counters SHALL saturate at 2^CNT_W-1, never wrap; saturated values are reported unchanged.
REQ-018 Timeout counter SHALL clear on any rise or fall, otherwise increment; reaching TIMEOUT in any non-stuck state -> S_STUCK, stuck = 1, stuck_level = s2, on the same edge.
REQ-019 S_STUCK: any edge -> stuck = 0 on the next edge; rise -> S_HIGH with no period_valid; fall -> S_LOW with no period_valid and the reference point invalid, so the next rise returns to S_HIGH without a pulse.
REQ-020 Latency: a led_in rise first sampled by s1 at edge k SHALL produce period_valid high in the cycle after edge k+2.
REQ-021 period, high_time and stuck_level SHALL hold their values until next updated; period_valid is high for exactly one cycle.
REQ-022 A rise and a timeout expiry on the same cycle: the edge wins, no stuck.

Reset
REQ-023 On rst_n low, asynchronously: s1/s2/s3 = 0, state = S_IDLE, all counters 0, period_valid = 0, period = 0, high_time = 0, stuck = 0, stuck_level = 0.
REQ-024 Reset mid-measurement SHALL discard the partial period; the first rise after release SHALL NOT pulse period_valid.

Structure
REQ-025 Package blink_pkg SHALL hold the monitor state enum (2-bit) and the default CNT_W/TIMEOUT constants, shared with the blink generator's state typedef.
REQ-026 Synchronizer SHALL be a separate sub-module sync_2ff (clk, rst_n, d, q), reset value 0.
REQ-027 All sequential logic SHALL use always_ff with async active-low reset; next-state logic SHALL be always_comb with a default branch to S_IDLE.

Verification
REQ-028 led_in toggling every clock (blink generator output) -> from the second rise, period_valid every 2 cycles, period = 2, high_time = 1, stuck = 0.
REQ-029 led_in 3 cycles high / 5 cycles low, repeated -> period = 8, high_time = 3 per pulse; the first rise produces no pulse.
REQ-030 TIMEOUT = 1000, led_in held high -> stuck = 1, stuck_level = 1 exactly 1000 cycles after the last edge; fall clears stuck next cycle; the first full period afterwards reports correctly.
REQ-031 rst_n pulsed low mid-high-phase -> all outputs 0 immediately; state S_IDLE; the next rise gives no pulse, the following rise gives a correct period.
REQ-032 CNT_W = 4, TIMEOUT = 15, 10 cycles high / 10 cycles low -> period = 15 (saturated), high_time = 10, stuck = 0.
REQ-033 Timeout expiry coinciding with a rise -> stuck stays 0 and measurement continues.
